// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Brief    : ALUControl encoding shared by the ALU decoder and execute unit.
//             ALU_EXT_OPS_EN enables the xor/sll/srl codes.
//  Revision : 1.0
// ============================================================================
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_ctrl_e;

    // Codes the execute unit can carry out in the current build.
    function automatic logic alu_ctrl_legal(input alu_ctrl_e ctrl);
        logic legal;
        case (ctrl)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT: legal = 1'b1;
`ifdef ALU_EXT_OPS_EN
            ALU_XOR, ALU_SLL, ALU_SRL:                  legal = 1'b1;
`endif
            default:                                    legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
//  Module   : alu_core
//  Brief    : Combinational ALU datapath (ctrl, a, b) -> (result, illegal).
//             ALU_EXT_OPS_EN adds xor and the zero-fill shifter.
//  Revision : 1.0
// ============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  alu_ctrl_e        ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             illegal
);

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_ovf;
    logic             w_lt;

    assign w_sum  = a + b;
    assign w_diff = a + ~b + {{(WIDTH-1){1'b0}}, 1'b1};
    // Signed overflow on a-b: operand signs differ and the difference sign differs from a.
    assign w_ovf  = (a[WIDTH-1] ^ b[WIDTH-1]) & (w_diff[WIDTH-1] ^ a[WIDTH-1]);
    assign w_lt   = w_diff[WIDTH-1] ^ w_ovf;

`ifdef ALU_EXT_OPS_EN
    localparam int SHW = $clog2(WIDTH);
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_shr;

    assign w_shamt = b[SHW-1:0];
    assign w_shl   = a << w_shamt;
    assign w_shr   = a >> w_shamt;
`endif

    assign illegal = ~alu_ctrl_legal(ctrl);

    always_comb begin
        result = '0;
        case (ctrl)
            ALU_ADD: result = w_sum;
            ALU_SUB: result = w_diff;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, w_lt};
`ifdef ALU_EXT_OPS_EN
            ALU_XOR: result = a ^ b;
            ALU_SLL: result = w_shl;
            ALU_SRL: result = w_shr;
`endif
            default: result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : alu_exec_unit
//  Brief    : Two-stage valid/ready ALU execute unit (operand capture, then
//             registered result + flags). ALU_EXT_OPS_EN enables xor/sll/srl.
//  Revision : 1.0
// ============================================================================
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Neg,
    output logic             Illegal
);

    logic             r_s1_valid;
    alu_ctrl_e        r_s1_ctrl;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_neg;
    logic             r_illegal;

    logic             w_adv2;
    logic             w_accept;
    logic [WIDTH-1:0] w_result;
    logic             w_illegal;

    // Stage 2 takes a new op when it is empty or its current result is being consumed.
    assign w_adv2   = r_s1_valid & (~r_s2_valid | out_ready);
    assign in_ready = ~r_s1_valid | w_adv2;
    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
        end else if (w_adv2) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Operand registers are only observed through r_s1_valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1_ctrl <= alu_ctrl_e'(ALUControl);
            r_s1_a    <= SrcA;
            r_s1_b    <= SrcB;
        end
    end

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .ctrl    (r_s1_ctrl),
        .a       (r_s1_a),
        .b       (r_s1_b),
        .result  (w_result),
        .illegal (w_illegal)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_neg      <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (w_adv2) begin
            r_s2_valid <= 1'b1;
            r_result   <= w_result;
            r_zero     <= (w_result == '0);
            r_neg      <= w_result[WIDTH-1];
            r_illegal  <= w_illegal;
        end else if (out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    assign out_valid = r_s2_valid;
    assign ALUResult = r_result;
    assign Zero      = r_zero;
    assign Neg       = r_neg;
    assign Illegal   = r_illegal;

endmodule
`default_nettype wire
